// File: rtl/ofifo_align.sv
// ofifo_align -- per-column output FIFO and row aligner behind the MAC array.
//
// Each MAC column finishes its psum on a different cycle, so each lane has
// its own write strobe and its own private FIFO. A full row, one entry from
// every lane, is released only when every lane holds at least one entry.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears pointers, counts, flags and out
//   in         col x bw_psum psum bus, lane i at [bw_psum*(i+1)-1 : bw_psum*i]
//   wr         per-lane write strobe
//   rd         pop one aligned row
//   out        registered aligned row, same packing as in
//   o_valid    every lane non-empty
//   o_full     some lane holds depth entries
//   o_ready    ~o_full
//   out_valid  one-cycle pulse after a successful pop
//   overflow   sticky: a write was dropped because its lane was full
//   underflow  sticky: rd arrived while o_valid was low

// One lane: depth x bw_psum storage with wrap-bit pointers.
module ofifo_lane #(
    parameter int bw_psum = 22,
    parameter int depth   = 64,
    parameter int ptr_w   = $clog2(depth)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw_psum-1:0] wdata,
    input  logic               wr,
    input  logic               pop,
    output logic [bw_psum-1:0] rdata,
    output logic               empty,
    output logic               full
);
    logic [bw_psum-1:0] mem_q [depth];
    logic [ptr_w:0]     wptr_q, wptr_d;
    logic [ptr_w:0]     rptr_q, rptr_d;
    logic [ptr_w:0]     cnt_q, cnt_d;
    logic               do_wr;

    assign empty = (wptr_q == rptr_q);
    // Same address, opposite wrap bit.
    assign full  = (wptr_q[ptr_w-1:0] == rptr_q[ptr_w-1:0]) &&
                   (wptr_q[ptr_w] != rptr_q[ptr_w]);
    assign rdata = mem_q[rptr_q[ptr_w-1:0]];

    // Full is sampled before the edge, so a write to a full lane is dropped
    // even when a pop frees a slot in the same cycle.
    assign do_wr = wr && !full;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (pop)   rptr_d = rptr_q + 1'b1;
        case ({do_wr, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is never cleared; pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (do_wr && !reset) mem_q[wptr_q[ptr_w-1:0]] <= wdata;
    end
endmodule

module ofifo_align #(
    parameter int col     = 8,
    parameter int bw_psum = 22,
    parameter int depth   = 64,
    parameter int ptr_w   = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*bw_psum-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   out_valid,
    output logic                   overflow,
    output logic                   underflow
);
    logic [col-1:0][bw_psum-1:0] in_lanes;
    logic [col-1:0][bw_psum-1:0] head;
    logic [col-1:0]              lane_empty;
    logic [col-1:0]              lane_full;
    logic                        pop;

    logic [col-1:0][bw_psum-1:0] out_q, out_d;
    logic                        out_valid_q, out_valid_d;
    logic                        overflow_q, overflow_d;
    logic                        underflow_q, underflow_d;

    assign in_lanes = in;

    // Flags come from registered pointers only.
    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;

    // A pop moves every lane together, keeping rows aligned.
    assign pop = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(
            .bw_psum (bw_psum),
            .depth   (depth),
            .ptr_w   (ptr_w)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wdata (in_lanes[i]),
            .wr    (wr[i]),
            .pop   (pop),
            .rdata (head[i]),
            .empty (lane_empty[i]),
            .full  (lane_full[i])
        );
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = pop;
        overflow_d  = overflow_q  || |(wr & lane_full);
        underflow_d = underflow_q || (rd && !o_valid);
        if (pop) out_d = head;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_ofifo_align.sv
// Directed + randomized bench for ofifo_align against a queue-based model.
module tb_ofifo_align;
    localparam int COL   = 8;
    localparam int BW    = 22;
    localparam int DEPTH = 64;
    localparam int W     = COL * BW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   in = '0;
    logic [COL-1:0] wr = '0;
    logic           rd = 1'b0;
    logic [W-1:0]   out;
    logic           o_valid, o_full, o_ready, out_valid, overflow, underflow;

    ofifo_align #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .wr        (wr),
        .rd        (rd),
        .out       (out),
        .o_valid   (o_valid),
        .o_full    (o_full),
        .o_ready   (o_ready),
        .out_valid (out_valid),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per lane, plus expected registered outputs.
    logic [BW-1:0] q [COL][$];
    logic [W-1:0]  m_out;
    logic          m_ov, m_of, m_uf;
    int            n_assert = 0;
    int            n_fail   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_valid();
        for (int i = 0; i < COL; i++) if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < COL; i++) if (q[i].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // Apply one cycle of stimulus, advance the model, then compare every output.
    task automatic cyc(input logic rst_v, input logic [COL-1:0] wr_v, input logic rd_v,
                       input logic [W-1:0] in_v);
        logic          v;
        logic [COL-1:0] lf;
        reset = rst_v; wr = wr_v; rd = rd_v; in = in_v;
        @(posedge clk);
        #1;
        if (rst_v) begin
            for (int i = 0; i < COL; i++) q[i].delete();
            m_out = '0; m_ov = 0; m_of = 0; m_uf = 0;
        end else begin
            v = m_valid();
            for (int i = 0; i < COL; i++) lf[i] = (q[i].size() == DEPTH);
            m_ov = 0;
            if (rd_v) begin
                if (v) begin
                    for (int i = 0; i < COL; i++) m_out[i*BW +: BW] = q[i].pop_front();
                    m_ov = 1;
                end else m_uf = 1;
            end
            for (int i = 0; i < COL; i++)
                if (wr_v[i]) begin
                    if (lf[i]) m_of = 1;
                    else q[i].push_back(in_v[i*BW +: BW]);
                end
        end
        chk("o_valid",   W'(o_valid),   W'(m_valid()));
        chk("o_full",    W'(o_full),    W'(m_full()));
        chk("o_ready",   W'(o_ready),   W'(!m_full()));
        chk("out_valid", W'(out_valid), W'(m_ov));
        chk("out",       out,           m_out);
        chk("overflow",  W'(overflow),  W'(m_of));
        chk("underflow", W'(underflow), W'(m_uf));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, '0);
    endtask

    // Staggered rows: row r lane i written at cycle r+i; data from dsel.
    task automatic stagger(input int rows, input int dsel, input logic pop_en);
        logic [COL-1:0] w;
        logic [W-1:0]   d;
        logic           r;
        for (int t = 0; t < rows + COL - 1; t++) begin
            w = '0; d = '0;
            for (int i = 0; i < COL; i++)
                if (t >= i && t - i < rows) begin
                    w[i] = 1'b1;
                    if (dsel == 0) d[i*BW +: BW] = BW'(16 * (t - i) + i);
                    else           d[i*BW +: BW] = BW'($urandom);
                end
            r = pop_en && m_valid();
            cyc(1'b0, w, r, d);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] expo;
        logic [COL-1:0] w;

        // Reset state.
        cyc(1'b1, '0, 1'b0, '0);
        cyc(1'b1, '0, 1'b0, '0);
        chk("reset_out", out, '0);
        chk("reset_ready", W'(o_ready), W'(1));

        // 1. Stagger alignment.
        for (int t = 0; t < COL; t++) begin
            d = '0;
            d[t*BW +: BW] = BW'(32'h100 + t);
            w = '0; w[t] = 1'b1;
            cyc(1'b0, w, 1'b0, d);
        end
        chk("stagger_valid", W'(o_valid), W'(1));
        cyc(1'b0, '0, 1'b1, '0);
        expo = '0;
        for (int i = 0; i < COL; i++) expo[i*BW +: BW] = BW'(32'h100 + i);
        chk("stagger_out", out, expo);
        chk("stagger_ov", W'(out_valid), W'(1));
        idle(2);

        // 2. Burst of five rows, then six reads (last one underflows).
        stagger(5, 0, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b0, '0, 1'b1, '0);
        chk("burst_uf", W'(underflow), W'(1));
        cyc(1'b1, '0, 1'b0, '0);

        // 3. Fill lane 3, then overflow it; lane data must survive.
        for (int k = 0; k < DEPTH; k++) begin
            d = '0; d[3*BW +: BW] = BW'(32'h3000 + k);
            cyc(1'b0, 8'h08, 1'b0, d);
        end
        chk("lane3_full", W'(o_full), W'(1));
        d = '0; d[3*BW +: BW] = BW'(22'h3FFFFF);
        cyc(1'b0, 8'h08, 1'b0, d);
        chk("lane3_of", W'(overflow), W'(1));
        d = $urandom;
        cyc(1'b0, 8'hF7, 1'b0, {6{d[31:0]}} ^ W'($urandom));
        cyc(1'b0, '0, 1'b1, '0);
        chk("lane3_head", W'(out[3*BW +: BW]), W'(32'h3000));
        cyc(1'b1, '0, 1'b0, '0);

        // 4. Wrap-around: 200 random staggered rows with continuous popping.
        stagger(200, 1, 1'b1);
        while (m_valid()) cyc(1'b0, '0, 1'b1, '0);
        idle(1);
        chk("wrap_no_flags", W'({overflow, underflow}), W'(0));

        // 5. Full on every lane, then simultaneous read and write.
        for (int k = 0; k < DEPTH; k++) cyc(1'b0, 8'hFF, 1'b0, {6{$urandom}});
        cyc(1'b0, 8'hFF, 1'b1, {6{$urandom}});
        chk("full_rw_of", W'(overflow), W'(1));
        chk("full_rw_cnt", W'(q[0].size()), W'(DEPTH - 1));
        for (int k = 0; k < DEPTH - 1; k++) cyc(1'b0, '0, 1'b1, '0);
        idle(1);
        chk("drained", W'(o_valid), W'(0));

        // 6. Reset mid-stream with three rows buffered.
        cyc(1'b1, '0, 1'b0, '0);
        stagger(3, 1, 1'b0);
        cyc(1'b1, '0, 1'b0, '0);
        chk("mid_reset_flags", W'({o_valid, o_full, overflow, underflow, out_valid}), W'(0));
        cyc(1'b0, '0, 1'b1, '0);
        chk("mid_reset_uf", W'(underflow), W'(1));
        stagger(1, 1, 1'b0);
        cyc(1'b0, '0, 1'b1, '0);
        idle(1);

        // Random traffic.
        cyc(1'b1, '0, 1'b0, '0);
        for (int k = 0; k < 400; k++)
            cyc(1'b0, COL'($urandom), 1'($urandom_range(0, 2) == 0), {6{$urandom}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
